// File: rtl/busy_table.sv
// Busy table: one busy bit per physical register with a registered busy count.
// Optional same-cycle writeback bypass on the read ports: QU_BUSY_TABLE_BYPASS_EN.
module busy_table #(
   parameter int PHY_RF_DEPTH = 128,
   localparam int AW = $clog2(PHY_RF_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          busy_table_wr_en,
   input  logic [AW-1:0] busy_table_wr_addr,
   input  logic          busy_table_data_in,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic          busy_a,
   output logic          busy_b,
   output logic [AW:0]   num_busy
);

   logic [PHY_RF_DEPTH-1:0] busy_q;
   logic [PHY_RF_DEPTH-1:0] busy_d;
   logic [AW:0]             num_busy_q;
   logic [AW:0]             num_busy_d;

   logic wr_ok;
   logic clr_ok;
   logic wr_inc;
   logic wr_dec;
   logic clr_dec;

   // Entry 0 is hard-wired ready; a clear colliding with a write yields to the write.
   assign wr_ok   = busy_table_wr_en && (busy_table_wr_addr != '0);
   assign clr_ok  = clr_en && (clr_addr != '0) &&
                    !(wr_ok && (busy_table_wr_addr == clr_addr));
   assign wr_inc  = wr_ok &&  busy_table_data_in && !busy_q[busy_table_wr_addr];
   assign wr_dec  = wr_ok && !busy_table_data_in &&  busy_q[busy_table_wr_addr];
   assign clr_dec = clr_ok && busy_q[clr_addr];

   always_comb begin
      busy_d = busy_q;
      if (clr_ok)
         busy_d[clr_addr] = 1'b0;
      if (wr_ok)
         busy_d[busy_table_wr_addr] = busy_table_data_in;
   end

   // Only real transitions move the count, so it always equals the popcount.
   assign num_busy_d = num_busy_q + (AW+1)'(wr_inc)
                                  - (AW+1)'(wr_dec)
                                  - (AW+1)'(clr_dec);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy_q     <= '0;
         num_busy_q <= '0;
      end else begin
         busy_q     <= busy_d;
         num_busy_q <= num_busy_d;
      end
   end

   assign num_busy = num_busy_q;

`ifdef QU_BUSY_TABLE_BYPASS_EN
   logic byp_a;
   logic byp_b;

   assign byp_a = clr_en && (clr_addr == rd_addr_a) &&
                  !(busy_table_wr_en && (busy_table_wr_addr == rd_addr_a));
   assign byp_b = clr_en && (clr_addr == rd_addr_b) &&
                  !(busy_table_wr_en && (busy_table_wr_addr == rd_addr_b));

   assign busy_a = busy_q[rd_addr_a] && !byp_a;
   assign busy_b = busy_q[rd_addr_b] && !byp_b;
`else
   assign busy_a = busy_q[rd_addr_a];
   assign busy_b = busy_q[rd_addr_b];
`endif

endmodule

// File: doc/busy_table.md
BUSY_TABLE -- requirements
Module: busy_table

Interface
REQ-001 SHALL have parameter PHY_RF_DEPTH, default 128: number of physical registers; power of two, at least 4.
REQ-002 SHALL define AW = $clog2(PHY_RF_DEPTH) as a derived localparam.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  pipeline flush; clears every entry.
REQ-006 SHALL have port busy_table_wr_en  input  1  write strobe from the map stage.
REQ-007 SHALL have port busy_table_wr_addr  input  AW  physical register targeted by the map stage.
REQ-008 SHALL have port busy_table_data_in  input  1  value to write (1 = busy, 0 = ready).
REQ-009 SHALL have port clr_en  input  1  writeback completion strobe.
REQ-010 SHALL have port clr_addr  input  AW  physical register written back.
REQ-011 SHALL have ports rd_addr_a and rd_addr_b  input  AW  issue-stage lookup addresses.
REQ-012 SHALL have ports busy_a and busy_b  output  1  busy status for rd_addr_a and rd_addr_b.
REQ-013 SHALL have port num_busy  output  AW+1  count of busy entries.

Function
REQ-014 SHALL hold one registered busy bit per physical register.
REQ-015 SHALL update the entry at busy_table_wr_addr with busy_table_data_in on each edge where busy_table_wr_en=1.
REQ-016 SHALL clear the entry at clr_addr on each edge where clr_en=1.
REQ-017 SHALL let the write port win when write and clear target the same address in one cycle; the entry takes busy_table_data_in.
REQ-018 SHALL perform both updates when write and clear target different addresses in one cycle.
REQ-019 SHALL ignore writes and clears to address 0; entry 0 always reads 0 (never busy).
REQ-020 SHALL drive busy_a and busy_b combinationally from the stored bits, with zero-cycle read latency.
REQ-021 SHALL let a write become visible on busy_a and busy_b from the cycle after the edge that performs it.
REQ-022 SHALL keep num_busy registered and equal to the popcount of the stored bits after every edge.
REQ-023 SHALL count only actual 0->1 transitions (+1) and 1->0 transitions (-1); redundant writes leave the count unchanged.
REQ-024 SHALL net both count adjustments in one update when both ports transition entries in the same cycle.
REQ-025 SHALL keep num_busy within 0..PHY_RF_DEPTH-1; it never wraps.
REQ-026 SHALL, when flush=1, clear all entries and num_busy at the edge; flush overrides the write and clear ports in that cycle.

Reset
REQ-027 SHALL, when rst=1 at an edge, clear all entries and set num_busy=0; reset has priority over flush, write and clear.
REQ-028 SHALL drive busy_a=busy_b=0 for every address in the cycle after reset.
REQ-029 SHALL discard any write or clear presented in a reset cycle.

Configuration
REQ-030 SHALL, when QU_BUSY_TABLE_BYPASS_EN is defined, force busy_a or busy_b to 0 in the same cycle whenever clr_en=1 and clr_addr matches that read address, unless the write port targets the same address that cycle.
REQ-031 SHALL, when QU_BUSY_TABLE_BYPASS_EN is undefined, include no bypass path; reads reflect stored state only.
REQ-032 SHALL behave identically with and without QU_BUSY_TABLE_BYPASS_EN for stored state and num_busy.

Verification
REQ-033 SHALL cover: reset, then write addr 5 data 1 -> busy_a(rd_addr_a=5)=1 next cycle, num_busy=1.
REQ-034 SHALL cover: entry 5 busy, clr_en with clr_addr=5 and rd_addr_a=5 -> busy_a=0 same cycle with bypass, next cycle without; num_busy=0 after the edge.
REQ-035 SHALL cover: write addr 0 data 1 -> busy_a(rd_addr_a=0)=0, num_busy unchanged.
REQ-036 SHALL cover: same cycle, write addr 7 data 1 and clr_addr=7 -> entry 7=1; write addr 9 data 1 with clear of busy addr 3 -> num_busy unchanged.
REQ-037 SHALL cover: set addrs 1..127 -> num_busy=127; then flush concurrent with a write to 4 -> all entries 0, num_busy=0.
REQ-038 SHALL cover: rst asserted mid-sequence with 10 entries busy and a pending write -> all clear, num_busy=0.
